alu_op_sequencer: RTL

Sequential initiator for the combinational n-bit ALU (Mode/A/B/CB_in -> Result/CB_out). It accepts operation commands over a valid/ready interface and drives registered operands into the ALU. After a programmable settle time it captures the ALU result and returns it over a valid/ready response interface. An optional chain bit feeds the previous carry/borrow into the next operation, enabling multi-word add/subtract.

---
 rtl/alu_op_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Sequential initiator for an external combinational N-bit ALU. It accepts one
// operation at a time and registers the operands onto the ALU inputs. After
// SETTLE cycles it captures the ALU outputs and offers them as a response.
// A chain bit lets an operation take the previous operation's carry/borrow
// as its CB_in, so multi-word add/subtract can be built from N-bit pieces.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low. The consumer may change ready at any time.
//
// Parameters:
//   N       operand/result width (N >= 1)
//   SETTLE  cycles from driving ALU inputs to sampling ALU outputs (>= 1)
//   CNT_W   width of the completed-operation counter
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_mode, cmd_a, cmd_b        command payload (mode encoding is the ALU's)
//   cmd_cb_in, cmd_chain          CB_in source: cmd_cb_in, or stored carry
//   alu_mode, alu_a, alu_b,
//   alu_cb_in                     registered drive into the ALU
//   alu_result, alu_cb_out        ALU outputs, sampled at the end of settling
//   rsp_valid / rsp_ready         response handshake
//   rsp_result, rsp_cb            captured ALU outputs
//   busy                          high whenever not idle
//   op_count                      completed response handshakes, wraps
//   state_dbg                     current FSM state (0 idle, 1 settle, 2 hold)
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int N      = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic             cmd_cb_in,
  input  logic             cmd_chain,

  output logic [2:0]       alu_mode,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic             alu_cb_in,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_cb_out,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_cb,

  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       state_dbg
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  // Settle counter only has to hold SETTLE-1; keep at least one bit so the
  // SETTLE=1 build still has a legal vector.
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE - 1);

  logic [1:0]      state;
  logic [SC_W-1:0] settle_cnt;
  logic            carry_reg;

  logic accept;
  logic capture;
  logic rsp_fire;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  assign accept   = cmd_valid && cmd_ready;
  // The edge on which the counter reads zero is the last settle cycle.
  assign capture  = (state == S_SETTLE) && (settle_cnt == '0);
  // rsp_valid is only ever high in HOLD, so no separate state qualifier.
  assign rsp_fire = rsp_valid && rsp_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (capture) state <= S_HOLD;
        end
        S_HOLD: begin
          // Return to IDLE only; the next accept happens a cycle later, so
          // a command and a response never complete on the same edge.
          if (rsp_fire) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (accept) begin
      settle_cnt <= SC_LOAD;
    end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // ALU drive registers: loaded only on accept and held otherwise, so the ALU
  // inputs stay put through settling, holding and the following idle time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_mode  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cb_in <= 1'b0;
    end else if (accept) begin
      alu_mode  <= cmd_mode;
      alu_a     <= cmd_a;
      alu_b     <= cmd_b;
      alu_cb_in <= cmd_chain ? carry_reg : cmd_cb_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Carry kept for chaining. Every capture updates it, chained or not, so a
  // multi-word sequence starts with an unchained low word and chains above.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg <= 1'b0;
    end else if (capture) begin
      carry_reg <= alu_cb_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cb     <= 1'b0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_cb     <= alu_cb_out;
    end else if (rsp_fire) begin
      // Payload is left in place; only the valid flag drops.
      rsp_valid  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-operation counter (wraps naturally at 2^CNT_W)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
